// File: rtl/lcd_ctrl.sv
`timescale 1ns/1ps
// lcd_ctrl: turns LSU LCD register writes into HD44780 setup/enable/hold/execution-wait pin timing.
// Defining LCD_INIT_EN adds a power-up wait and a built-in initialisation command sequence.
module lcd_ctrl #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PW    = 12,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_EXEC  = 2000,
  parameter int unsigned T_LONG  = 80000,
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned CNT_W   = 20
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_io_lcd,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic        o_overrun
);

  localparam longint unsigned CNT_LIM = 64'(1) << CNT_W;

  if (T_SETUP == 0 || T_PW == 0 || T_HOLD == 0 || T_EXEC == 0 || T_LONG == 0 || T_PWRUP == 0 ||
      64'(T_SETUP) >= CNT_LIM || 64'(T_PW) >= CNT_LIM || 64'(T_HOLD) >= CNT_LIM ||
      64'(T_EXEC) >= CNT_LIM || 64'(T_LONG) >= CNT_LIM || 64'(T_PWRUP) >= CNT_LIM) begin : g_cnt_chk
    $error("lcd_ctrl: timing parameters must be nonzero and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] PW_LAST    = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(T_LONG - 1);

  typedef enum logic [2:0] {S_IDLE, S_PWRUP, S_SETUP, S_PULSE, S_HOLD, S_EXEC} state_e;

`ifdef LCD_INIT_EN
  localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(T_PWRUP - 1);
  localparam state_e RST_STATE = S_PWRUP;
`else
  localparam state_e RST_STATE = S_IDLE;
`endif

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             strobe_q;
  logic [7:0]       data_q;
  logic             rs_q;
  logic             en_q;
  logic             on_q;
  logic             busy_q;
  logic             ovr_q;
  logic             long_q;
`ifdef LCD_INIT_EN
  logic [2:0]       idx_q;
  logic             init_q;
`endif

  logic req_c;
  logic unused_io;
  assign req_c     = i_io_lcd[10] & ~strobe_q;
  assign unused_io = ^{i_io_lcd[30:11], i_io_lcd[8]};

  // Clear/home commands need the long execution wait.
  function automatic logic is_long(input logic rs, input logic [7:0] d);
    return !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
  endfunction

`ifdef LCD_INIT_EN
  function automatic logic [7:0] init_byte(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: return 8'h38;
      3'd3:             return 8'h0C;
      3'd4:             return 8'h01;
      default:          return 8'h06;
    endcase
  endfunction
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
      data_q   <= 8'h00;
      rs_q     <= 1'b0;
      en_q     <= 1'b0;
      on_q     <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      long_q   <= 1'b0;
`ifdef LCD_INIT_EN
      idx_q    <= 3'd0;
      init_q   <= 1'b1;
`endif
    end else begin
      strobe_q <= i_io_lcd[10];
      on_q     <= i_io_lcd[31];
      if (req_c && state_q != S_IDLE) ovr_q <= 1'b1;
      case (state_q)
        S_IDLE: if (req_c) begin
          data_q  <= i_io_lcd[7:0];
          rs_q    <= i_io_lcd[9];
          long_q  <= is_long(i_io_lcd[9], i_io_lcd[7:0]);
          ovr_q   <= 1'b0;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_SETUP;
        end
        S_SETUP: if (cnt_q == SETUP_LAST) begin
          cnt_q   <= '0;
          en_q    <= 1'b1;
          state_q <= S_PULSE;
        end else cnt_q <= cnt_q + CNT_W'(1);
        S_PULSE: if (cnt_q == PW_LAST) begin
          cnt_q   <= '0;
          en_q    <= 1'b0;
          state_q <= S_HOLD;
        end else cnt_q <= cnt_q + CNT_W'(1);
        S_HOLD: if (cnt_q == HOLD_LAST) begin
          cnt_q   <= '0;
          state_q <= S_EXEC;
        end else cnt_q <= cnt_q + CNT_W'(1);
        S_EXEC: if (cnt_q == (long_q ? LONG_LAST : EXEC_LAST)) begin
          cnt_q <= '0;
`ifdef LCD_INIT_EN
          if (init_q && idx_q != 3'd5) begin
            idx_q   <= idx_q + 3'd1;
            data_q  <= init_byte(idx_q + 3'd1);
            long_q  <= is_long(1'b0, init_byte(idx_q + 3'd1));
            state_q <= S_SETUP;
          end else begin
            init_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
`else
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
`endif
        end else cnt_q <= cnt_q + CNT_W'(1);
`ifdef LCD_INIT_EN
        // First cycle after reset only raises busy so the wait spans T_PWRUP busy cycles.
        S_PWRUP: if (!busy_q) begin
          busy_q <= 1'b1;
        end else if (cnt_q == PWRUP_LAST) begin
          cnt_q   <= '0;
          idx_q   <= 3'd0;
          init_q  <= 1'b1;
          data_q  <= init_byte(3'd0);
          rs_q    <= 1'b0;
          long_q  <= is_long(1'b0, init_byte(3'd0));
          state_q <= S_SETUP;
        end else cnt_q <= cnt_q + CNT_W'(1);
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_lcd_data = data_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = en_q;
  assign o_lcd_on   = on_q;
  assign o_busy     = busy_q;
  assign o_overrun  = ovr_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
`timescale 1ns/1ps
// tb_lcd_ctrl: directed vector table plus hand-written corner sequences for lcd_ctrl.
module tb_lcd_ctrl;

  localparam int unsigned T_SETUP = 2;
  localparam int unsigned T_PW    = 4;
  localparam int unsigned T_HOLD  = 2;
  localparam int unsigned T_EXEC  = 10;
  localparam int unsigned T_LONG  = 50;
  localparam int unsigned T_PWRUP = 20;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_io_lcd;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy, o_overrun;

  lcd_ctrl #(
    .T_SETUP(T_SETUP), .T_PW(T_PW), .T_HOLD(T_HOLD), .T_EXEC(T_EXEC),
    .T_LONG(T_LONG), .T_PWRUP(T_PWRUP), .CNT_W(20)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_io_lcd(i_io_lcd),
    .o_lcd_data(o_lcd_data), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
    .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on), .o_busy(o_busy), .o_overrun(o_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] io;
    logic [7:0]  data;
    logic        rs;
    int          busy;
  } vec_t;

  vec_t vecs [8];
  int   errors = 0;
  int   checks = 0;
  int   busy_len, en_len, en_start, rises;
  logic prev_en;
`ifdef LCD_INIT_EN
  int         pulses, gap, gap5;
  logic [7:0] seen [6];
  logic [7:0] init_exp [6];
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one write and measure busy length and EN pulse position relative to the accept edge.
  task automatic run_txn(input logic [31:0] io, output int b_len, output int e_len, output int e_start);
    b_len = 0; e_len = 0; e_start = -1;
    @(negedge i_clk); i_io_lcd = io;
    for (int k = 0; k < 400; k++) begin
      @(posedge i_clk); #1;
      if (o_lcd_en) begin
        e_len++;
        if (e_start < 0) e_start = k;
      end
      if (o_busy) b_len++;
      else break;
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 1000; k++) begin
      @(posedge i_clk); #1;
      if (!o_busy) break;
    end
    chk("wait_idle", 32'(o_busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0641, 8'h41, 1'b1, 18};
    vecs[1] = '{32'h0000_0401, 8'h01, 1'b0, 58};
    vecs[2] = '{32'h0000_0400, 8'h00, 1'b0, 18};
    vecs[3] = '{32'h0000_0402, 8'h02, 1'b0, 58};
    vecs[4] = '{32'h0000_0403, 8'h03, 1'b0, 58};
    vecs[5] = '{32'h0000_0404, 8'h04, 1'b0, 18};
    vecs[6] = '{32'h0000_0601, 8'h01, 1'b1, 18};
    vecs[7] = '{32'h8000_04FF, 8'hFF, 1'b0, 18};

    i_rst_n  = 1'b0;
    i_io_lcd = 32'h0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_data", 32'(o_lcd_data), 32'h0);
    chk("rst_rs", 32'(o_lcd_rs), 32'h0);
    chk("rst_rw", 32'(o_lcd_rw), 32'h0);
    chk("rst_en", 32'(o_lcd_en), 32'h0);
    chk("rst_on", 32'(o_lcd_on), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_ovr", 32'(o_overrun), 32'h0);
    @(negedge i_clk); i_rst_n = 1'b1;

`ifdef LCD_INIT_EN
    init_exp[0] = 8'h38; init_exp[1] = 8'h38; init_exp[2] = 8'h38;
    init_exp[3] = 8'h0C; init_exp[4] = 8'h01; init_exp[5] = 8'h06;
    busy_len = 0; pulses = 0; gap = 0; gap5 = -1; prev_en = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge i_clk); #1;
      if (k == 5) i_io_lcd = 32'h0000_0641;
      if (o_lcd_en && !prev_en) begin
        if (pulses < 6) seen[pulses] = o_lcd_data;
        if (pulses == 5) gap5 = gap;
        pulses++;
        gap = 0;
      end else if (!o_lcd_en && pulses > 0) gap++;
      prev_en = o_lcd_en;
      if (o_busy) busy_len++;
      else break;
    end
    chk("init_busy_len", 32'(busy_len), 32'd168);
    chk("init_pulses", 32'(pulses), 32'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("init_byte%0d", i), 32'(seen[i]), 32'(init_exp[i]));
    chk("init_clear_gap", 32'(gap5), 32'd54);
    chk("init_ovr", 32'(o_overrun), 32'd1);
    chk("init_rs", 32'(o_lcd_rs), 32'd0);
    @(negedge i_clk); i_io_lcd = 32'h0;
    @(negedge i_clk);
`else
    @(posedge i_clk); #1;
    chk("post_rst_busy", 32'(o_busy), 32'h0);
    chk("post_rst_en", 32'(o_lcd_en), 32'h0);
`endif

    // Table-driven single writes.
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].io, busy_len, en_len, en_start);
      chk($sformatf("v%0d_busy", i), 32'(busy_len), 32'(vecs[i].busy));
      chk($sformatf("v%0d_en_len", i), 32'(en_len), 32'(T_PW));
      chk($sformatf("v%0d_en_start", i), 32'(en_start), 32'(T_SETUP));
      chk($sformatf("v%0d_data", i), 32'(o_lcd_data), 32'(vecs[i].data));
      chk($sformatf("v%0d_rs", i), 32'(o_lcd_rs), 32'(vecs[i].rs));
      chk($sformatf("v%0d_rw", i), 32'(o_lcd_rw), 32'd0);
      chk($sformatf("v%0d_on", i), 32'(o_lcd_on), 32'(vecs[i].io[31]));
      chk($sformatf("v%0d_ovr", i), 32'(o_overrun), 32'd0);
      @(negedge i_clk); i_io_lcd = 32'h0;
      @(negedge i_clk);
    end

    // Strobe dropped while busy sets sticky overrun; next accept clears it.
    @(negedge i_clk); i_io_lcd = 32'h0000_0641;
    repeat (3) @(negedge i_clk);
    i_io_lcd = 32'h0000_0041;
    @(negedge i_clk); i_io_lcd = 32'h0000_0642;
    repeat (2) @(negedge i_clk);
    chk("ovr_set", 32'(o_overrun), 32'd1);
    chk("ovr_data_kept", 32'(o_lcd_data), 32'h41);
    chk("ovr_busy", 32'(o_busy), 32'd1);
    wait_idle();
    chk("ovr_sticky", 32'(o_overrun), 32'd1);
    @(negedge i_clk); i_io_lcd = 32'h0;
    @(negedge i_clk); i_io_lcd = 32'h0000_0643;
    @(posedge i_clk); #1;
    chk("ovr_clear", 32'(o_overrun), 32'd0);
    chk("ovr_new_data", 32'(o_lcd_data), 32'h43);
    wait_idle();
    @(negedge i_clk); i_io_lcd = 32'h0;
    @(negedge i_clk);

    // Held strobe gives exactly one EN pulse.
    @(negedge i_clk); i_io_lcd = 32'h0000_0641;
    rises = 0; prev_en = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge i_clk); #1;
      if (o_lcd_en && !prev_en) rises++;
      prev_en = o_lcd_en;
    end
    chk("hold_one_pulse", 32'(rises), 32'd1);
    chk("hold_idle", 32'(o_busy), 32'd0);

    // ON bit follows bit 31 with one cycle of latency, no EN activity.
    @(negedge i_clk); i_io_lcd = 32'h8000_0000;
    chk("on_before_edge", 32'(o_lcd_on), 32'd0);
    @(posedge i_clk); #1;
    chk("on_after_edge", 32'(o_lcd_on), 32'd1);
    en_len = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge i_clk); #1;
      if (o_lcd_en || o_busy) en_len++;
    end
    chk("on_no_activity", 32'(en_len), 32'd0);

    // Reset asserted mid-pulse clears everything immediately.
    @(negedge i_clk); i_io_lcd = 32'h8000_0641;
    for (int k = 0; k < 20; k++) begin
      @(posedge i_clk); #1;
      if (o_lcd_en) break;
    end
    chk("pulse_reached", 32'(o_lcd_en), 32'd1);
    @(negedge i_clk); i_rst_n = 1'b0; i_io_lcd = 32'h0;
    #1;
    chk("arst_en", 32'(o_lcd_en), 32'd0);
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_data", 32'(o_lcd_data), 32'd0);
    chk("arst_rs", 32'(o_lcd_rs), 32'd0);
    chk("arst_on", 32'(o_lcd_on), 32'd0);
    @(negedge i_clk); i_rst_n = 1'b1;
`ifdef LCD_INIT_EN
    repeat (2) @(posedge i_clk);
    wait_idle();
`endif
    @(negedge i_clk);
    run_txn(32'h0000_0655, busy_len, en_len, en_start);
    chk("after_rst_busy", 32'(busy_len), 32'd18);
    chk("after_rst_data", 32'(o_lcd_data), 32'h55);
    chk("after_rst_rs", 32'(o_lcd_rs), 32'd1);
    chk("after_rst_en", 32'(en_len), 32'(T_PW));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Bus sequencer between the LSU's memory-mapped LCD output register (o_io_lcd word) and HD44780-style character-LCD pins.
- Software writes a command/data byte plus a strobe bit. The block generates setup, enable-pulse, hold and execution-wait timing, then frees itself for the next write.
- o_busy is fed back into the input-memory map so software can poll it.

Parameters:
- T_SETUP, 2, cycles RS/DATA stable before EN rises
- T_PW, 12, cycles EN held high (240 ns at 50 MHz)
- T_HOLD, 2, cycles RS/DATA held after EN falls
- T_EXEC, 2000, execution wait for normal commands and data writes
- T_LONG, 80000, execution wait for clear/home commands
- T_PWRUP, 750000, power-up wait (used only with LCD_INIT_EN)
- CNT_W, 20, timing counter width; must hold the largest T_* value

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_io_lcd  in  32  LSU LCD register: [31]=ON, [10]=STROBE, [9]=RS, [7:0]=DATA; all other bits ignored
- o_lcd_data  out  8  LCD data bus
- o_lcd_rs  out  1  register select
- o_lcd_rw  out  1  read/write; constant 0 (write only)
- o_lcd_en  out  1  enable strobe
- o_lcd_on  out  1  LCD power/backlight
- o_busy  out  1  transaction or init in progress
- o_overrun  out  1  sticky: strobe rising edge was dropped while busy

Behaviour:
- Reset: async, forces state IDLE, counter 0, strobe-edge register 0.
  - All outputs 0 immediately, including mid-transaction.
  - With LCD_INIT_EN, reset release enters PWRUP instead of IDLE.
- o_lcd_on: i_io_lcd[31] registered, 1-cycle latency, independent of the FSM.
- Request detection: req = i_io_lcd[10] & ~strobe_q. strobe_q registers bit 10 every cycle. Holding STROBE high yields exactly one request.
- Accept (edge where req=1 and state=IDLE):
  - Latch DATA into o_lcd_data and RS into o_lcd_rs.
  - Clear o_overrun, o_busy<=1, go to SETUP, counter reset.
- Request while not IDLE: ignored; o_lcd_data/o_lcd_rs unchanged; o_overrun<=1.
- FSM: IDLE -> SETUP -> PULSE -> HOLD -> EXEC -> IDLE.
  - SETUP: T_SETUP cycles, EN=0.
  - PULSE: T_PW cycles, EN=1.
  - HOLD: T_HOLD cycles, EN=0.
  - EXEC: T_EXEC or T_LONG cycles, EN=0.
  - Each state lasts exactly its parameter in cycles; counter reloads on every state change.
- Timing relative to accept edge A:
  - EN high from edge A+T_SETUP to A+T_SETUP+T_PW.
  - o_busy falls at edge A+T_SETUP+T_PW+T_HOLD+Twait.
  - A new request is acceptable in the cycle after that (back-to-back allowed).
- Wait selection:
  - Twait=T_LONG when latched RS=0 and DATA in {0x01,0x02,0x03}.
  - Otherwise Twait=T_EXEC, including RS=0 with DATA=0x00.
- o_lcd_data/o_lcd_rs hold their last value in IDLE until the next accept.
- o_lcd_rw tied to 0 at all times.
- Counter never wraps: every T_* < 2^CNT_W, checked by elaboration assertion.

Optional Feature:
- Macro LCD_INIT_EN.
- Defined:
  - After reset release, FSM enters PWRUP with o_busy=1 and waits T_PWRUP cycles.
  - Then issues a 6-entry internal ROM sequence, RS=0: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
  - Each entry uses the SETUP/PULSE/HOLD/EXEC timing and wait selection above (0x01 gets T_LONG).
  - o_busy stays 1 continuously from reset release until the last EXEC completes, then IDLE.
  - Software strobes during init are dropped and set o_overrun.
- Undefined: no PWRUP/ROM logic; reset goes directly to IDLE with o_busy=0.

Test Plan (bench params T_SETUP=2, T_PW=4, T_HOLD=2, T_EXEC=10, T_LONG=50, T_PWRUP=20):
- i_io_lcd 0x0000_0000 -> 0x0000_0641 at edge A -> data=0x41, rs=1, rw=0; en high edges A+2..A+6; busy high exactly 18 cycles.
- i_io_lcd -> 0x0000_0401 (clear) -> rs=0, data=0x01; busy exactly 58 cycles. Repeat with 0x0000_0400 -> busy 18 cycles.
- During busy of 0x641, drop bit 10 then write 0x0000_0642 -> ignored, data stays 0x41, o_overrun=1. Next accepted strobe -> o_overrun=0.
- Hold 0x0000_0641 for 100 cycles -> exactly one EN pulse. Write 0x8000_0000 -> o_lcd_on=1 one cycle later, no EN activity.
- Assert i_rst_n low during PULSE -> en, busy, data, rs, on all 0 same cycle. After release, new strobe is accepted normally.
- With LCD_INIT_EN: release reset -> busy high 168 cycles; six EN pulses with data 38, 38, 38, 0C, 01, 06; 0x01 followed by 50-cycle wait.
